// File: rtl/dotp_sequencer.sv
// rtl/dotp_sequencer.sv - chunking host controller for the 4-bit dot-product engine
// Optional WAIT timeout and drain path enabled by defining DOTP_SEQ_TIMEOUT_EN.
module dotp_sequencer #(
  parameter int TIMEOUT_CYC = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       in_last,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       busy,
  output logic       err,
  output logic       eng_rst_n,
  output logic [1:0] eng_op,
  output logic [5:0] eng_addr,
  output logic [3:0] eng_wdata,
  input  logic [1:0] eng_state,
  input  logic [7:0] eng_result
);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] ES_DONE  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_JRST,
    S_CLR_LO,
    S_CLR_HI,
    S_ACCEPT,
    S_WR_A,
    S_WR_B,
    S_LEN,
    S_RUN,
    S_WAIT,
    S_CRST,
    S_RESULT
`ifdef DOTP_SEQ_TIMEOUT_EN
    , S_DRAIN
`endif
  } state_t;

  state_t     state, state_d;
  logic [3:0] idx, idx_d;
  logic [4:0] n, n_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       last_q, last_d;
  logic [7:0] res_d;
  logic       err_d;
  logic       in_ready_d, res_valid_d, busy_d, eng_rst_n_d;
  logic [1:0] op_d;
  logic [5:0] addr_d;
  logic [3:0] wdata_d;

`ifdef DOTP_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d = state;
    idx_d   = idx;
    n_d     = n;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    res_d   = res_data;
    err_d   = 1'b0;
`ifdef DOTP_SEQ_TIMEOUT_EN
    wait_cnt_d = '0;
`endif
    case (state)
      S_IDLE:   if (in_valid) state_d = S_JRST;
      S_JRST: begin
        idx_d   = '0;
        n_d     = '0;
        state_d = S_CLR_LO;
      end
      S_CLR_LO: state_d = S_CLR_HI;
      S_CLR_HI: state_d = S_ACCEPT;
      S_ACCEPT: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          last_d  = in_last;
          state_d = S_WR_A;
        end
      end
      S_WR_A:   state_d = S_WR_B;
      S_WR_B: begin
        n_d     = n + 5'd1;
        idx_d   = idx + 4'd1;
        state_d = (last_q || n == 5'd15) ? S_LEN : S_ACCEPT;
      end
      S_LEN:    state_d = S_RUN;
      S_RUN:    state_d = S_WAIT;
      S_WAIT: begin
        if (eng_state == ES_DONE) begin
          if (last_q) begin
            res_d   = eng_result;
            state_d = S_RESULT;
          end else begin
            state_d = S_CRST;
          end
        end
`ifdef DOTP_SEQ_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = last_q ? S_IDLE : S_DRAIN;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
`endif
      end
      // Engine memory keeps the partial sum; only state and prev_acc are cleared.
      S_CRST: begin
        idx_d   = '0;
        n_d     = '0;
        state_d = S_ACCEPT;
      end
      S_RESULT: if (res_ready) state_d = S_IDLE;
`ifdef DOTP_SEQ_TIMEOUT_EN
      S_DRAIN:  if (in_valid && in_ready && in_last) state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    in_ready_d  = 1'b0;
    res_valid_d = 1'b0;
    busy_d      = (state_d != S_IDLE);
    eng_rst_n_d = 1'b1;
    op_d        = OP_READ;
    addr_d      = 6'd0;
    wdata_d     = 4'd0;
    case (state_d)
      S_JRST, S_CRST: eng_rst_n_d = 1'b0;
      S_CLR_LO: begin
        op_d   = OP_WRITE;
        addr_d = 6'd33;
      end
      S_CLR_HI: begin
        op_d   = OP_WRITE;
        addr_d = 6'd34;
      end
      S_ACCEPT: in_ready_d = 1'b1;
      S_WR_A: begin
        op_d    = OP_WRITE;
        addr_d  = 6'd1 + {2'b00, idx_d};
        wdata_d = a_d;
      end
      S_WR_B: begin
        op_d    = OP_WRITE;
        addr_d  = 6'd17 + {2'b00, idx_d};
        wdata_d = b_d;
      end
      S_LEN: begin
        op_d    = OP_WRITE;
        wdata_d = n_d[3:0];
      end
      S_RUN:    op_d = OP_RUN;
      S_RESULT: res_valid_d = 1'b1;
`ifdef DOTP_SEQ_TIMEOUT_EN
      S_DRAIN: begin
        eng_rst_n_d = 1'b0;
        in_ready_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      n         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      last_q    <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      eng_rst_n <= 1'b0;
      eng_op    <= OP_READ;
      eng_addr  <= '0;
      eng_wdata <= '0;
`ifdef DOTP_SEQ_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      n         <= n_d;
      a_q       <= a_d;
      b_q       <= b_d;
      last_q    <= last_d;
      res_data  <= res_d;
      err       <= err_d;
      in_ready  <= in_ready_d;
      res_valid <= res_valid_d;
      busy      <= busy_d;
      eng_rst_n <= eng_rst_n_d;
      eng_op    <= op_d;
      eng_addr  <= addr_d;
      eng_wdata <= wdata_d;
`ifdef DOTP_SEQ_TIMEOUT_EN
      wait_cnt  <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dotp_sequencer.sv
// tb/tb_dotp_sequencer.sv - scoreboard bench for dotp_sequencer with a behavioural engine
module tb_dotp_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, in_last;
  logic [3:0] in_a, in_b;
  logic       res_valid, res_ready, busy, err, eng_rst_n;
  logic [7:0] res_data, eng_result;
  logic [1:0] eng_op, eng_state;
  logic [5:0] eng_addr;
  logic [3:0] eng_wdata;

  always #5 clk = ~clk;

  dotp_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy), .err(err),
    .eng_rst_n(eng_rst_n), .eng_op(eng_op), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_state(eng_state), .eng_result(eng_result)
  );

  // Engine: RUN -> RUNNING -> ACCUM -> DONE, adding products into words 33/34.
  logic [3:0] mem [0:34];
  logic [1:0] est;
  logic       stall;
  assign eng_state  = est;
  assign eng_result = {mem[34], mem[33]};

  function automatic logic [7:0] eng_sum();
    logic [7:0] s;
    int len;
    s   = {mem[34], mem[33]};
    len = (mem[0] == 4'd0) ? 16 : int'(mem[0]);
    for (int i = 0; i < len; i++) s += {4'b0, mem[1+i]} * {4'b0, mem[17+i]};
    return s;
  endfunction

  always @(posedge clk) begin
    if (!eng_rst_n) est <= 2'd0;
    else begin
      if (eng_op == 2'd1 && eng_addr <= 6'd34) mem[eng_addr] <= eng_wdata;
      case (est)
        2'd0: if (eng_op == 2'd2 && !stall) est <= 2'd1;
        2'd1: est <= 2'd3;
        2'd3: begin
          est <= 2'd2;
          {mem[34], mem[33]} <= eng_sum();
        end
        default: ;
      endcase
    end
  end

  int n_cmp = 0, n_fail = 0;
  int overlap_cnt = 0, err_cnt = 0, rst_low_cnt = 0;
  logic [7:0] exp_res[$];
  logic [3:0] exp_len[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: results and LEN writes are checked against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) check("res_unexpected", {24'b0, res_data}, 32'hffff_ffff);
        else check("res_data", {24'b0, res_data}, {24'b0, exp_res.pop_front()});
      end
      if (eng_op == 2'd1 && eng_addr == 6'd0) begin
        if (exp_len.size() == 0) check("len_unexpected", {28'b0, eng_wdata}, 32'hffff_ffff);
        else check("len_data", {28'b0, eng_wdata}, {28'b0, exp_len.pop_front()});
      end
      if (in_ready && res_valid) overlap_cnt++;
      if (err) err_cnt++;
      if (!eng_rst_n) rst_low_cnt++;
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
    int t;
    t = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 400);
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_job(input logic [3:0] a, input logic [3:0] b, input int cnt);
    for (int i = 0; i < cnt; i++) send(a, b, i == cnt - 1);
    wait_idle();
  endtask

  localparam logic [25:0] RST_VALS = 26'd0;

  initial begin
    int lat, base;
    for (int i = 0; i <= 34; i++) mem[i] = 4'd0;
    est = 2'd0; stall = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = 4'd0; in_b = 4'd0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {6'b0, in_ready, res_valid, busy, err, eng_rst_n, eng_op, eng_addr,
                            eng_wdata, res_data}, {6'b0, RST_VALS});
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single pair 3x5, latency from handshake to res_valid
    exp_res.push_back(8'h0F); exp_len.push_back(4'd1);
    send(4'd3, 4'd5, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 50);
    check("single_latency", lat, 8);
    wait_idle();

    // full chunk of 16, LEN written as 0
    exp_res.push_back(8'h10); exp_len.push_back(4'd0);
    run_job(4'd15, 4'd15, 16);

    // 20 pairs split 16+4, JRST plus one CRST pulse
    base = rst_low_cnt;
    exp_res.push_back(8'h78); exp_len.push_back(4'd0); exp_len.push_back(4'd4);
    run_job(4'd2, 4'd3, 20);
    check("rst_pulses_20", rst_low_cnt - base, 2);

    // back-to-back jobs: accumulator must not carry over
    exp_res.push_back(8'h01); exp_len.push_back(4'd1);
    run_job(4'd1, 4'd1, 1);
    exp_res.push_back(8'h04); exp_len.push_back(4'd1);
    run_job(4'd2, 4'd2, 1);

    // result held while consumer stalls
    res_ready = 1'b0;
    exp_res.push_back(8'h10); exp_len.push_back(4'd1);
    send(4'd4, 4'd4, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 50);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_outputs", {21'b0, res_valid, res_data, in_ready, busy}, {21'b0, 1'b1, 8'h10, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle();

    // reset during WR_B discards the job
    send(4'd1, 4'd1, 1'b0);
    @(posedge clk); #1;
    check("wrb_addr", {26'b0, eng_addr}, 32'd17);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midjob_reset", {6'b0, in_ready, res_valid, busy, err, eng_rst_n, eng_op, eng_addr,
                           eng_wdata, res_data}, {6'b0, RST_VALS});
    rst_n = 1'b1;
    exp_res.push_back(8'h0F); exp_len.push_back(4'd1);
    run_job(4'd3, 4'd5, 1);

`ifdef DOTP_SEQ_TIMEOUT_EN
    // engine never leaves RESET: abort, drain the 17th pair, no result
    base = err_cnt;
    stall = 1'b1;
    exp_len.push_back(4'd0);
    run_job(4'd1, 4'd1, 17);
    check("timeout_err_pulses", err_cnt - base, 1);
    stall = 1'b0;
`else
    check("err_never", err_cnt, 0);
`endif

    repeat (5) @(negedge clk);
    check("res_queue_empty", exp_res.size(), 0);
    check("len_queue_empty", exp_len.size(), 0);
    check("ready_valid_overlap", overlap_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dotp_sequencer.md
# dotp_sequencer

Host-side controller for the 4-bit dot-product engine. It accepts a stream of (a, b) element pairs of any length, splits the stream into chunks of up to 16 pairs, and writes each chunk into the engine's vector memory. It then issues RUN and resets the engine between chunks, so the engine's accumulate path carries the partial sum forward. When the stream ends it returns the final 8-bit result (modulo 256) over a valid/ready handshake.

## Interface
Parameters:
- TIMEOUT_CYC, 7: cycles allowed in WAIT before abort (only used with `DOTP_SEQ_TIMEOUT_EN`).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  element pair valid
- in_ready  out  1  sequencer accepts a pair
- in_a  in  4  element of vector A
- in_b  in  4  element of vector B
- in_last  in  1  final pair of job
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  8  dot product mod 256
- busy  out  1  job in progress (state != IDLE)
- err  out  1  one-cycle abort pulse
- eng_rst_n  out  1  engine reset, active-low
- eng_op  out  2  engine opcode: 0 READ, 1 WRITE, 2 RUN
- eng_addr  out  6  engine address: 0 length, 1..16 A, 17..32 B, 33/34 result lo/hi
- eng_wdata  out  4  engine write data
- eng_state  in  2  engine state: 0 RESET, 1 RUNNING, 3 ACCUM, 2 DONE
- eng_result  in  8  engine result {mem[34], mem[33]}

## Operation
- All outputs are registered. The engine samples the bus on the clock edge after a state is entered. In every state not listed below the bus is op READ, addr 0, wdata 0.
- IDLE: in_ready=0. in_valid=1 moves to JRST.
- JRST: eng_rst_n=0 for one cycle. Next: CLR_LO.
- CLR_LO: WRITE addr 33 with data 0. Next: CLR_HI.
- CLR_HI: WRITE addr 34 with data 0. Next: ACCEPT. Together these clear the carried accumulator.
- ACCEPT: in_ready=1. On handshake, capture a, b and last, then go to WR_A.
- WR_A: WRITE addr 1+idx with data a. Next: WR_B.
- WR_B: WRITE addr 17+idx with data b. Increment the chunk count n (1..16). If last or n==16, go to LEN; otherwise return to ACCEPT.
- LEN: WRITE addr 0 with data n[3:0]. 16 is written as 0, which the engine treats as 16. Next: RUN.
- RUN: op RUN for exactly one cycle. Next: WAIT.
- WAIT: op READ; wait for eng_state==DONE.
  - On DONE with a non-last chunk: go to CRST.
  - On DONE with the last chunk: capture eng_result into res_data and go to RESULT.
- CRST: eng_rst_n=0 for one cycle, which clears engine state and prev_acc. Clear idx and n. Next: ACCEPT. The result words stay in engine memory, so the next RUN adds them in.
- RESULT: res_valid=1. res_data is held stable until res_ready=1, then go to IDLE.
- Arithmetic: 4×4 products, sum modulo 256. A job longer than 16 pairs accumulates across chunks modulo 256.
- busy=1 in every state except IDLE.
- Reset (rst_n=0), which overrides everything:
  - state IDLE; idx=0, n=0.
  - eng_rst_n=0; eng_op/addr/wdata=0.
  - in_ready=0, res_valid=0, res_data=0, busy=0, err=0.
  - Reset mid-job discards the job. The next job's JRST and CLR writes guarantee a clean start.
- in_valid or in_last seen in any state other than ACCEPT is ignored; it is not consumed.

## Timing
- Per pair with in_valid held high: 3 cycles (ACCEPT, WR_A, WR_B).
- Chunk overhead: LEN 1 + RUN 1 + WAIT ≥3 + CRST 1.
- If RUN is at cycle k: engine RUNNING at k+1, ACCUM at k+2, DONE first visible at k+3. WAIT exits at the k+3 edge.
- Job start: IDLE to first in_ready takes 4 cycles (IDLE, JRST, CLR_LO, CLR_HI).
- Minimum latency, single pair, from accept to res_valid: WR_A, WR_B, LEN, RUN, then 3 WAIT cycles = res_valid in the 8th cycle after the handshake.
- in_ready and res_valid are never high in the same cycle.

## Configuration
- With `DOTP_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT. If DONE is not seen within TIMEOUT_CYC cycles, err pulses for 1 cycle and the block goes to DRAIN.
  - DRAIN: eng_rst_n=0, in_ready=1. Pairs are discarded through the one with last=1, then IDLE. If the aborted chunk was the last chunk, go directly to IDLE.
  - No res_valid is produced for an aborted job.
- Without the macro: WAIT waits indefinitely; err is tied to 0; the DRAIN state does not exist.

## Test plan
- Single pair a=3, b=5, last → writes to addr 1, 17 and 0 (data 1), then RUN; res_data=0x0F, res_valid held until res_ready.
- 16 pairs, all a=15, b=15 → LEN writes 0, one RUN; res_data=0x10 (3600 mod 256).
- 20 pairs, all a=2, b=3 → chunks of 16 and 4. LEN data is 0 then 4; one CRST pulse between chunks; res_data=0x78.
- Two back-to-back jobs (1×1, then 2×2) → second result 0x04, not 0x05; proves the CLR writes clear the carried accumulator.
- res_ready held low for 10 cycles after res_valid → res_data stable, in_ready=0, busy=1.
- rst_n low during WR_B → next cycle all outputs at reset values. A following job 3×5 returns 0x0F.
- (`DOTP_SEQ_TIMEOUT_EN`) eng_state forced to 0 after RUN → err pulse 7 cycles after WAIT entry, remaining pairs drained through last, no res_valid.
